// File: rtl/program_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : program_rom_responder
// Purpose  : Instruction-fetch responder with a UART byte-stream download path
//            into program memory. Optional running checksum: PROGROM_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
module program_rom_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          DEPTH      = 16384,
    parameter logic [31:0] NOP_WORD   = 32'h0
) (
    input  logic                  iCpuClock,
    input  logic                  iCpuReset,
    input  logic [ADDR_WIDTH-1:0] iFetchAddr,
    output logic [31:0]           oInstruction,
    input  logic                  iUpgStart,
    input  logic                  iUpgByteValid,
    input  logic [7:0]            iUpgByte,
    input  logic                  iUpgEnd,
    output logic                  oBusy,
    output logic                  oUpgDone,
    output logic                  oUpgOverflow,
    output logic [ADDR_WIDTH:0]   oWordCount,
    output logic [7:0]            oChecksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE_WORD = 1;

    state_t      state;
    state_t      nextState;
    logic [1:0]  byteCnt;
    logic [23:0] wordBuf;
    logic [31:0] mem [DEPTH];

    logic                  memFull;
    logic                  acceptByte;
    logic                  fullWrite;
    logic                  flushWrite;
    logic                  memWe;
    logic [31:0]           memData;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  nextBusy;

    // Word address and word count advance together, so the count doubles as
    // the write pointer; its top bit marks that the last address was written.
    assign memFull    = oWordCount[ADDR_WIDTH];
    assign acceptByte = (state == LOAD) && iUpgByteValid && !memFull;
    assign fullWrite  = acceptByte && (byteCnt == 2'd3);
    assign flushWrite = (state == FLUSH) && (byteCnt != 2'd0);
    assign memWe      = fullWrite || flushWrite;
    assign memData    = fullWrite ? {iUpgByte, wordBuf} : {8'h00, wordBuf};
    assign memAddr    = oWordCount[ADDR_WIDTH-1:0];

    assign oBusy    = (state == LOAD) || (state == FLUSH);
    assign oUpgDone = (state == DONE);
    assign nextBusy = (nextState == LOAD) || (nextState == FLUSH);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iUpgStart) nextState = LOAD;
            LOAD:    if (iUpgEnd)   nextState = FLUSH;
            FLUSH:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Unfilled lanes of wordBuf stay zero, which provides the flush padding.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            byteCnt      <= 2'd0;
            wordBuf      <= 24'h0;
            oWordCount   <= '0;
            oUpgOverflow <= 1'b0;
        end else begin
            if ((state == IDLE) && iUpgStart) begin
                byteCnt      <= 2'd0;
                wordBuf      <= 24'h0;
                oWordCount   <= '0;
                oUpgOverflow <= 1'b0;
            end else if (state == LOAD) begin
                if (iUpgByteValid && memFull) begin
                    oUpgOverflow <= 1'b1;
                end else if (acceptByte) begin
                    if (byteCnt == 2'd3) begin
                        byteCnt    <= 2'd0;
                        wordBuf    <= 24'h0;
                        oWordCount <= oWordCount + ONE_WORD;
                    end else begin
                        case (byteCnt)
                            2'd0:    wordBuf[7:0]   <= iUpgByte;
                            2'd1:    wordBuf[15:8]  <= iUpgByte;
                            default: wordBuf[23:16] <= iUpgByte;
                        endcase
                        byteCnt <= byteCnt + 2'd1;
                    end
                end
            end else if (state == FLUSH) begin
                if (byteCnt != 2'd0) begin
                    oWordCount <= oWordCount + ONE_WORD;
                end
                byteCnt <= 2'd0;
                wordBuf <= 24'h0;
            end
        end
    end

    always_ff @(posedge iCpuClock) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    // Fetch is frozen as soon as a download is entered, so reads and writes
    // never share a cycle.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            oInstruction <= 32'h0;
        end else if (nextBusy) begin
            oInstruction <= NOP_WORD;
        end else if (state == IDLE) begin
            oInstruction <= mem[iFetchAddr];
        end
    end

`ifdef PROGROM_CHECKSUM_EN
    logic [7:0] checksum;

    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            checksum <= 8'h00;
        end else if ((state == IDLE) && iUpgStart) begin
            checksum <= 8'h00;
        end else if (acceptByte) begin
            checksum <= checksum + iUpgByte;
        end
    end

    assign oChecksum = checksum;
`else
    assign oChecksum = 8'h00;
`endif

endmodule
`default_nettype wire
